int_alu_mc: RTL and testbench

- Parametrised multicycle integer ALU; successor to the single-cycle 64-bit integer ALU in the CPU datapath.
- Executes MIPS R-type funct operations on WIDTH-bit operands, including iterative multiply/divide.
- Architectural HI/LO registers, valid/ready handshakes on issue and result sides, and overflow/illegal-op flags.
- Sits between register-read and writeback; the pipeline stalls on in_ready low.

---
 rtl/int_alu_mc.sv | 181 ++++++++++++++++++
 tb/tb_int_alu_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_alu_mc.sv
// Multicycle MIPS R-type integer ALU with HI/LO; 1 edge for simple ops, WIDTH+1 edges for mult/div.
// Accepts only in IDLE (in_ready); the result is held in DONE until out_ready.
module int_alu_mc #(
    parameter int WIDTH = 64
) (
    input  logic             c,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_state_nx;

    logic [WIDTH-1:0] r_result, r_hi, r_lo, r_a, r_p_hi, r_p_lo, r_mcand;
    logic             r_ovf, r_err, r_is_div, r_neg_q, r_neg_r;
    logic [SW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_res, w_sum, w_dif, w_a_mag, w_b_mag;
    logic             w_ovf, w_err, w_mc, w_wr_hi, w_wr_lo, w_accept, w_a_neg, w_b_neg;
    logic [SW-1:0]    w_sh;

    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        w_mc    = 1'b0;
        w_wr_hi = 1'b0;
        w_wr_lo = 1'b0;
        w_sum   = a + b;
        w_dif   = a - b;
        w_sh    = b[SW-1:0];
        case (funct)
            6'b100000: begin w_res = w_sum; w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]); end
            6'b100001: w_res = w_sum;
            6'b100010: begin w_res = w_dif; w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]); end
            6'b100011: w_res = w_dif;
            6'b100100: w_res = a & b;
            6'b100101: w_res = a | b;
            6'b100110: w_res = a ^ b;
            6'b100111: w_res = ~(a | b);
            6'b101010: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            6'b101011: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            6'b000000, 6'b000100: w_res = a << w_sh;
            6'b000010, 6'b000110: w_res = a >> w_sh;
            6'b000011, 6'b000111: w_res = $signed(a) >>> w_sh;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: w_mc = 1'b1;
            6'b010000: w_res = r_hi;
            6'b010010: w_res = r_lo;
            6'b010001: begin w_res = a; w_wr_hi = 1'b1; end
            6'b010011: begin w_res = a; w_wr_lo = 1'b1; end
            default:   w_err = 1'b1;
        endcase
    end

    // Iterative engines run on magnitudes; signs are re-applied on the last iteration.
    assign w_a_neg = ~funct[0] & a[WIDTH-1];
    assign w_b_neg = ~funct[0] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    logic [WIDTH:0]     w_msum, w_rs, w_trial;
    logic [WIDTH-1:0]   w_hi_nx, w_lo_nx, w_q, w_r, w_fin_hi, w_fin_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;

    always_comb begin
        w_msum  = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_mcand} : '0);
        w_rs    = {r_p_hi, r_p_lo[WIDTH-1]};
        w_trial = w_rs - {1'b0, r_mcand};
        if (r_is_div) begin
            w_hi_nx = w_trial[WIDTH] ? w_rs[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_lo_nx = {r_p_lo[WIDTH-2:0], ~w_trial[WIDTH]};
        end else begin
            w_hi_nx = w_msum[WIDTH:1];
            w_lo_nx = {w_msum[0], r_p_lo[WIDTH-1:1]};
        end
        w_prod = r_neg_q ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
        w_q    = r_neg_q ? -w_lo_nx : w_lo_nx;
        w_r    = r_neg_r ? -w_hi_nx : w_hi_nx;
        if (!r_is_div) begin
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod[WIDTH-1:0];
        end else if (r_mcand == '0) begin
            w_fin_hi = r_a;
            w_fin_lo = '1;
        end else begin
            w_fin_hi = w_r;
            w_fin_lo = w_q;
        end
    end

    assign w_last   = (r_state == BUSY) && (&r_cnt);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge c or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nx = w_mc ? BUSY : DONE;
            end
            BUSY: if (&r_cnt) w_state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            if (w_mc) begin
                r_p_hi   <= '0;
                r_p_lo   <= w_a_mag;
                r_mcand  <= w_b_mag;
                r_a      <= a;
                r_is_div <= funct[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_cnt    <= '0;
            end else begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                r_err    <= w_err;
                if (w_wr_hi) r_hi <= a;
                if (w_wr_lo) r_lo <= a;
            end
        end else if (r_state == BUSY) begin
            r_cnt  <= r_cnt + 1'b1;
            r_p_hi <= w_hi_nx;
            r_p_lo <= w_lo_nx;
            if (w_last) begin
                r_hi     <= w_fin_hi;
                r_lo     <= w_fin_lo;
                r_result <= w_fin_lo;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

    assign result = r_result;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign ovf    = r_ovf & out_valid;
    assign err    = r_err & out_valid;
endmodule

// File: tb/tb_int_alu_mc.sv
// Bench for int_alu_mc at WIDTH=64 and WIDTH=8 against an arithmetic reference model.
module tb_int_alu_mc;
    logic c = 1'b0;
    always #5 c = ~c;

    int checks = 0;
    int failures = 0;

    logic        rst64 = 1'b1, iv64 = 1'b0, ir64, ov64, or64 = 1'b0, ovf64, err64;
    logic [5:0]  f64 = '0;
    logic [63:0] a64 = '0, b64 = '0, res64, hi64, lo64;
    logic        rst8 = 1'b1, iv8 = 1'b0, ir8, ov8, or8 = 1'b0, ovf8, err8;
    logic [5:0]  f8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, res8, hi8, lo8;

    int_alu_mc #(.WIDTH(64)) u64 (
        .c(c), .rst(rst64), .in_valid(iv64), .in_ready(ir64), .funct(f64), .a(a64), .b(b64),
        .out_valid(ov64), .out_ready(or64), .result(res64), .hi(hi64), .lo(lo64), .ovf(ovf64), .err(err64));

    int_alu_mc #(.WIDTH(8)) u8 (
        .c(c), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .funct(f8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .result(res8), .hi(hi8), .lo(lo8), .ovf(ovf8), .err(err8));

    logic [63:0] m_hi64 = '0, m_lo64 = '0, m_hi8 = '0, m_lo8 = '0;
    logic [63:0] e_res64 = '0, e_hi64 = '0, e_lo64 = '0, e_res8 = '0, e_hi8 = '0, e_lo8 = '0;
    logic        e_ovf64 = 1'b0, e_err64 = 1'b0, e_ovf8 = 1'b0, e_err8 = 1'b0;
    logic [63:0] cap_res, cap_hi, cap_lo;
    logic        cap_ovf, cap_err;
    int          cap_lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    function automatic logic signed [127:0] sx(input int w, input logic [63:0] x);
        if (w == 8) return {{120{x[7]}}, x[7:0]};
        return {{64{x[63]}}, x};
    endfunction

    function automatic logic [127:0] zx(input int w, input logic [63:0] x);
        if (w == 8) return {120'd0, x[7:0]};
        return {64'd0, x};
    endfunction

    // Reference: plain wide arithmetic on the mathematical values, then truncation to w bits.
    task automatic model(input int w, input logic [5:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] hi_in, input logic [63:0] lo_in,
                         output logic [63:0] res, output logic [63:0] hi, output logic [63:0] lo,
                         output logic ovf, output logic err);
        logic signed [127:0] s, q;
        logic [127:0] u, mask;
        logic [63:0] m, am, bm;
        int sh;
        mask = (w == 8) ? 128'hFF : {64'd0, {64{1'b1}}};
        m  = mask[63:0];
        am = a & m;
        bm = b & m;
        sh = int'(b[5:0]) & (w - 1);
        res = '0; hi = hi_in; lo = lo_in; ovf = 1'b0; err = 1'b0;
        case (f)
            6'h20, 6'h21: begin s = sx(w, a) + sx(w, b); res = 64'(s & mask); ovf = (f == 6'h20) && (s != sx(w, res)); end
            6'h22, 6'h23: begin s = sx(w, a) - sx(w, b); res = 64'(s & mask); ovf = (f == 6'h22) && (s != sx(w, res)); end
            6'h24: res = am & bm;
            6'h25: res = am | bm;
            6'h26: res = am ^ bm;
            6'h27: res = ~(am | bm) & m;
            6'h2A: res = (sx(w, a) < sx(w, b)) ? 64'd1 : 64'd0;
            6'h2B: res = (am < bm) ? 64'd1 : 64'd0;
            6'h00, 6'h04: res = (am << sh) & m;
            6'h02, 6'h06: res = am >> sh;
            6'h03, 6'h07: begin s = sx(w, a) >>> sh; res = 64'(s) & m; end
            6'h18, 6'h19: begin
                if (f == 6'h18) begin s = sx(w, a) * sx(w, b); u = s; end
                else u = zx(w, a) * zx(w, b);
                hi = 64'((u >> w) & mask); lo = 64'(u & mask); res = lo;
            end
            6'h1A, 6'h1B: begin
                if (bm == 64'd0) begin lo = m; hi = am; end
                else if (f == 6'h1A) begin
                    q = sx(w, a) / sx(w, b); s = sx(w, a) % sx(w, b);
                    lo = 64'(q & mask); hi = 64'(s & mask);
                end else begin
                    u = zx(w, a) / zx(w, b); lo = 64'(u & mask);
                    u = zx(w, a) % zx(w, b); hi = 64'(u & mask);
                end
                res = lo;
            end
            6'h10: res = hi_in;
            6'h12: res = lo_in;
            6'h11: begin hi = am; res = am; end
            6'h13: begin lo = am; res = am; end
            default: err = 1'b1;
        endcase
    endtask

    // Continuous comparison against the model's expectation for the op in flight.
    always @(negedge c) begin
        if (ov64) begin
            chk("cmp64_res", res64, e_res64);
            chk("cmp64_hi", hi64, e_hi64);
            chk("cmp64_lo", lo64, e_lo64);
            chk("cmp64_flags", {62'd0, ovf64, err64}, {62'd0, e_ovf64, e_err64});
        end else chk("cmp64_flags_invalid", {62'd0, ovf64, err64}, 64'd0);
        if (ov8) begin
            chk("cmp8_res", {56'd0, res8}, e_res8);
            chk("cmp8_hi", {56'd0, hi8}, e_hi8);
            chk("cmp8_lo", {56'd0, lo8}, e_lo8);
            chk("cmp8_flags", {62'd0, ovf8, err8}, {62'd0, e_ovf8, e_err8});
        end else chk("cmp8_flags_invalid", {62'd0, ovf8, err8}, 64'd0);
    end

    task automatic issue(input bit s8, input logic [5:0] f, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] r, h, l;
        logic o, e;
        int n;
        if (s8) model(8, f, a, b, m_hi8, m_lo8, r, h, l, o, e);
        else    model(64, f, a, b, m_hi64, m_lo64, r, h, l, o, e);
        @(negedge c);
        if (s8) begin
            e_res8 = r; e_hi8 = h; e_lo8 = l; e_ovf8 = o; e_err8 = e;
            f8 = f; a8 = a[7:0]; b8 = b[7:0]; iv8 = 1'b1;
        end else begin
            e_res64 = r; e_hi64 = h; e_lo64 = l; e_ovf64 = o; e_err64 = e;
            f64 = f; a64 = a; b64 = b; iv64 = 1'b1;
        end
        n = 0;
        while (!(s8 ? ir8 : ir64) && n < 50) begin @(negedge c); n++; end
        if (n >= 50) begin timeout_fail("issue_accept"); iv8 = 1'b0; iv64 = 1'b0; return; end
        @(posedge c); #1;
        iv8 = 1'b0; iv64 = 1'b0;
        cap_lat = 1;
        while (!(s8 ? ov8 : ov64) && cap_lat < 200) begin @(posedge c); #1; cap_lat++; end
        if (!(s8 ? ov8 : ov64)) begin timeout_fail("issue_result"); return; end
        cap_res = s8 ? {56'd0, res8} : res64;
        cap_hi  = s8 ? {56'd0, hi8} : hi64;
        cap_lo  = s8 ? {56'd0, lo8} : lo64;
        cap_ovf = s8 ? ovf8 : ovf64;
        cap_err = s8 ? err8 : err64;
        repeat (hold) begin
            @(negedge c);
            chk("hold_res", s8 ? {56'd0, res8} : res64, cap_res);
            chk("hold_in_ready", {63'd0, s8 ? ir8 : ir64}, 64'd0);
            chk("hold_out_valid", {63'd0, s8 ? ov8 : ov64}, 64'd1);
        end
        @(negedge c);
        if (s8) or8 = 1'b1; else or64 = 1'b1;
        @(posedge c); #1;
        chk("ret_idle", {62'd0, s8 ? ir8 : ir64, s8 ? ov8 : ov64}, 64'd2);
        or8 = 1'b0; or64 = 1'b0;
        if (s8) begin m_hi8 = h; m_lo8 = l; end
        else begin m_hi64 = h; m_lo64 = l; end
    endtask

    localparam logic [5:0] SWEEP [12] = '{6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                          6'h2A, 6'h2B, 6'h00, 6'h06, 6'h07, 6'h11};

    initial begin
        repeat (2) @(negedge c);
        chk("rst64_in_ready", {63'd0, ir64}, 64'd1);
        chk("rst64_out_valid", {63'd0, ov64}, 64'd0);
        chk("rst64_hilo_res", hi64 | lo64 | res64, 64'd0);
        chk("rst8_in_ready", {63'd0, ir8}, 64'd1);
        chk("rst8_hilo_res", {40'd0, hi8, lo8, res8}, 64'd0);
        rst64 = 1'b0; rst8 = 1'b0;

        issue(0, 6'h20, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        chk("add64_res", cap_res, 64'h8000_0000_0000_0000);
        chk("add64_ovf", {63'd0, cap_ovf}, 64'd1);
        chk("add64_lat", 64'(cap_lat), 64'd1);
        issue(0, 6'h21, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        chk("addu64_ovf", {63'd0, cap_ovf}, 64'd0);
        issue(0, 6'h3F, 64'h1234, 64'h5678, 0);
        chk("bad64_err", {63'd0, cap_err}, 64'd1);
        chk("bad64_res", cap_res, 64'd0);
        issue(0, 6'h22, 64'h8000_0000_0000_0000, 64'd1, 0);
        chk("sub64_ovf", {63'd0, cap_ovf}, 64'd1);
        issue(0, 6'h18, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0);
        chk("mult64_hi", cap_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mult64_lo", cap_lo, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mult64_lat", 64'(cap_lat), 64'd65);
        issue(0, 6'h1A, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
        chk("div64_lo", cap_lo, 64'hFFFF_FFFF_FFFF_FFF2);
        chk("div64_hi", cap_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(0, 6'h19, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        issue(0, 6'h10, 64'd0, 64'd0, 0);
        chk("mfhi64", cap_res, 64'hFFFF_FFFF_FFFF_FFFE);

        issue(1, 6'h03, 64'h80, 64'd3, 0);
        chk("sra8", cap_res, 64'hF0);
        issue(1, 6'h02, 64'h80, 64'd3, 0);
        chk("srl8", cap_res, 64'h10);
        issue(1, 6'h04, 64'h41, 64'h09, 0);
        chk("sllv8", cap_res, 64'h82);
        issue(1, 6'h2A, 64'hFF, 64'h01, 0);
        chk("slt8", cap_res, 64'd1);
        issue(1, 6'h2B, 64'hFF, 64'h01, 0);
        chk("sltu8", cap_res, 64'd0);
        issue(1, 6'h18, 64'hFD, 64'h05, 0);
        chk("mult8_hi", cap_hi, 64'hFF);
        chk("mult8_lo", cap_lo, 64'hF1);
        chk("mult8_lat", 64'(cap_lat), 64'd9);
        issue(1, 6'h19, 64'hFD, 64'h05, 0);
        chk("multu8_hi", cap_hi, 64'h04);
        chk("multu8_lo", cap_lo, 64'hF1);
        issue(1, 6'h1A, 64'hF9, 64'h02, 0);
        chk("div8_lo", cap_lo, 64'hFD);
        chk("div8_hi", cap_hi, 64'hFF);
        chk("div8_lat", 64'(cap_lat), 64'd9);
        issue(1, 6'h1B, 64'h07, 64'h00, 0);
        chk("divu0_lo", cap_lo, 64'hFF);
        chk("divu0_hi", cap_hi, 64'h07);
        chk("divu0_err", {63'd0, cap_err}, 64'd0);
        issue(1, 6'h1A, 64'h80, 64'hFF, 0);
        chk("divmin_lo", cap_lo, 64'h80);
        chk("divmin_hi", cap_hi, 64'h00);

        issue(1, 6'h24, 64'hF0, 64'h3C, 5);
        chk("hs_and", cap_res, 64'h30);
        issue(1, 6'h12, 64'h00, 64'h00, 0);
        chk("hs_mflo", cap_res, 64'h80);

        for (int i = 0; i < 12; i++) issue(1, SWEEP[i], 64'hB5, 64'h13, 0);
        issue(1, 6'h1A, 64'h85, 64'hFD, 0);
        issue(1, 6'h11, 64'h5A, 64'h00, 0);

        @(negedge c);
        f8 = 6'h18; a8 = 8'h07; b8 = 8'h09; iv8 = 1'b1;
        @(posedge c); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge c);
        #2 rst8 = 1'b1;
        #1;
        chk("rstmid_out_valid", {63'd0, ov8}, 64'd0);
        chk("rstmid_hi", {56'd0, hi8}, 64'd0);
        chk("rstmid_lo", {56'd0, lo8}, 64'd0);
        chk("rstmid_in_ready", {63'd0, ir8}, 64'd1);
        @(negedge c);
        rst8 = 1'b0; m_hi8 = '0; m_lo8 = '0;
        issue(1, 6'h20, 64'd2, 64'd3, 0);
        chk("rstmid_add", cap_res, 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
